// File: rtl/demux1_3_tdm.sv
// demux1_3_tdm: registered 1-to-3 TDM demultiplexer with frame sync and misalignment flag
module demux1_3_tdm #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic             frame_valid,
  output logic             sync_err,
  output logic [1:0]       slot
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, q0_q, q0_d, q1_q, q1_d, q2_q, q2_d;
  logic [1:0] slot_q, slot_d;
  logic fv_q, fv_d, se_q, se_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      q0_q    <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
      slot_q  <= 2'd0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      slot_q  <= slot_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  always_comb begin
    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    slot_d  = slot_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    if (en && sync) begin
      // a sync landing on a partial frame drops it and restarts at slot 0
      s0_d    = din;
      slot_d  = 2'd1;
      state_d = RUN;
      se_d    = (state_q == RUN) && (slot_q != 2'd0);
    end else if (en && state_q == RUN) begin
      if (slot_q == 2'd0) begin
        s0_d   = din;
        slot_d = 2'd1;
      end else if (slot_q == 2'd1) begin
        s1_d   = din;
        slot_d = 2'd2;
      end else begin
        q0_d   = s0_q;
        q1_d   = s1_q;
        q2_d   = din;
        fv_d   = 1'b1;
        slot_d = 2'd0;
      end
    end
  end
  assign q0          = q0_q;
  assign q1          = q1_q;
  assign q2          = q2_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign slot        = slot_q;
endmodule
